// File: rtl/morse_tx_sequencer.sv
// Morse letter sequencer: queues letters A-H and plays them as timed marks and gaps
// on a single light output, timed in prescaled ticks.
module morse_tx_sequencer #(
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned LETTER_GAP  = 3,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ld_ltr,
  input  logic [2:0]                   in_ltr,
  output logic                         light_on,
  output logic                         busy,
  output logic                         ltr_done,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic [2:0]                   curr_state
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TICK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MARK  = 3'd2,
    S_SPACE = 3'd3,
    S_LGAP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      dur_q, dur_d;
  logic [2:0]      sym_q, sym_d;
  logic [3:0]      pat_q, pat_d;
  logic [2:0]      ltr_q;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            light_q, busy_q, done_q, full_q, ovf_q;

  logic            tick_c, expire_c, pop_c, push_c, drop_c, full_c;
  logic [6:0]      lut_c;

  // Code table: {length, pattern}; bit0 is the first symbol, 1 = dash.
  function automatic logic [6:0] code_lut(input logic [2:0] l);
    case (l)
      3'd0:    code_lut = {3'd2, 4'b0010};
      3'd1:    code_lut = {3'd4, 4'b0001};
      3'd2:    code_lut = {3'd4, 4'b0101};
      3'd3:    code_lut = {3'd3, 4'b0001};
      3'd4:    code_lut = {3'd1, 4'b0000};
      3'd5:    code_lut = {3'd4, 4'b0100};
      3'd6:    code_lut = {3'd3, 4'b0011};
      default: code_lut = {3'd4, 4'b0000};
    endcase
  endfunction

  assign tick_c   = (tick_q == TW'(TICK_CYCLES - 1));
  assign expire_c = tick_c && (dur_q == 3'd1);
  assign full_c   = (count_q == CW'(FIFO_DEPTH));
  assign pop_c    = (state_d == S_LOAD) && (state_q != S_LOAD);
  assign push_c   = ld_ltr && (!full_c || pop_c);
  assign drop_c   = ld_ltr && full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
  end

  // Next-state, tick and symbol bookkeeping
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    sym_d   = sym_q;
    pat_d   = pat_q;
    lut_c   = code_lut(ltr_q);
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        tick_d  = '0;
        sym_d   = lut_c[6:4];
        pat_d   = lut_c[3:0];
        dur_d   = lut_c[0] ? 3'd3 : 3'd1;
        state_d = S_MARK;
      end
      S_MARK, S_SPACE, S_LGAP: begin
        if (expire_c) begin
          tick_d = '0;
          case (state_q)
            S_MARK: begin
              if (sym_q > 3'd1) begin
                state_d = S_SPACE;
                dur_d   = 3'd1;
              end else begin
                state_d = S_LGAP;
                dur_d   = 3'(LETTER_GAP);
              end
            end
            S_SPACE: begin
              pat_d   = pat_q >> 1;
              sym_d   = sym_q - 3'd1;
              dur_d   = pat_q[1] ? 3'd3 : 3'd1;
              state_d = S_MARK;
            end
            default: state_d = (count_q != '0) ? S_LOAD : S_IDLE;
          endcase
        end else if (tick_c) begin
          tick_d = '0;
          dur_d  = dur_q - 3'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      dur_q    <= '0;
      sym_q    <= '0;
      pat_q    <= '0;
      ltr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      light_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
      sym_q    <= sym_d;
      pat_q    <= pat_d;
      if (pop_c)  ltr_q    <= mem_q[rd_ptr_q];
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q  <= count_d;
      light_q  <= (state_d == S_MARK);
      busy_q   <= (state_d != S_IDLE);
      // Pulse lands on the final LGAP cycle: predicted one cycle ahead
      done_q   <= (state_d == S_LGAP) && (tick_d == TW'(TICK_CYCLES - 1)) && (dur_d == 3'd1);
      full_q   <= (count_d == CW'(FIFO_DEPTH));
      ovf_q    <= drop_c;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_ltr;
  end

  assign light_on   = light_q;
  assign busy       = busy_q;
  assign ltr_done   = done_q;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign curr_state = state_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Scoreboard bench for morse_tx_sequencer: stimulus queues expected letters, a
// monitor measures each played letter and compares it at ltr_done.
module tb_morse_tx_sequencer;

  localparam int unsigned TICK  = 4;
  localparam int unsigned GAP   = 3;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ld_ltr;
  logic [2:0] in_ltr;
  logic       light_on, busy, ltr_done, fifo_full, overflow;
  logic [2:0] fifo_count;
  logic [2:0] curr_state;

  morse_tx_sequencer #(
    .TICK_CYCLES(TICK),
    .LETTER_GAP (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld_ltr    (ld_ltr),
    .in_ltr    (in_ltr),
    .light_on  (light_on),
    .busy      (busy),
    .ltr_done  (ltr_done),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .curr_state(curr_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  int ovf_seen = 0;

  // Hand-derived per letter: mark count, mark widths in cycles, MARK..LGAP cycles
  int exp_len[8]   = '{2, 4, 4, 3, 1, 4, 3, 4};
  int exp_w[8][4]  = '{'{4, 12, 0, 0}, '{12, 4, 4, 4}, '{12, 4, 12, 4}, '{12, 4, 4, 0},
                       '{4, 0, 0, 0},  '{4, 4, 12, 4}, '{12, 12, 4, 0}, '{4, 4, 4, 4}};
  int exp_tot[8]   = '{32, 48, 56, 40, 16, 48, 48, 40};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor
  int mon_run = 0, mon_nm = 0, mon_tot = 0, mon_l = 0;
  int mon_w[4];

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_run = 0;
      mon_nm  = 0;
      mon_tot = 0;
    end else begin
      if (overflow) ovf_seen++;
      if (curr_state == 3'd1) begin
        mon_run = 0;
        mon_nm  = 0;
        mon_tot = 0;
      end else if (curr_state inside {3'd2, 3'd3, 3'd4}) begin
        mon_tot++;
      end
      if (light_on) begin
        mon_run++;
      end else if (mon_run > 0) begin
        if (mon_nm < 4) mon_w[mon_nm] = mon_run;
        mon_nm++;
        mon_run = 0;
      end
      if (ltr_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_ltr_done", 1, 0);
        end else begin
          mon_l = sb.pop_front();
          chk($sformatf("mark_count_ltr%0d", mon_l), mon_nm, exp_len[mon_l]);
          for (int i = 0; i < exp_len[mon_l] && i < mon_nm && i < 4; i++)
            chk($sformatf("mark_width_ltr%0d_sym%0d", mon_l, i), mon_w[i], exp_w[mon_l][i]);
          chk($sformatf("letter_time_ltr%0d", mon_l), mon_tot, exp_tot[mon_l]);
        end
      end
    end
  end

  // Caller sits at a negedge; returns at the next negedge with ld_ltr low
  task automatic push(input int c);
    ld_ltr = 1'b1;
    in_ltr = 3'(c);
    @(negedge clk);
    ld_ltr = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || fifo_count != 3'd0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seq;
    logic [2:0] prev;

    reset_n = 1'b0;
    ld_ltr  = 1'b0;
    in_ltr  = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_light_on",   int'(light_on),   0);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_ltr_done",   int'(ltr_done),   0);
    chk("rst_fifo_full",  int'(fifo_full),  0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_overflow",   int'(overflow),   0);
    chk("rst_curr_state", int'(curr_state), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // E: timing of the push -> LOAD -> MARK path and busy length
    sb.push_back(4);
    push(4);
    chk("e_cyc0_state", int'(curr_state), 0);
    chk("e_cyc0_count", int'(fifo_count), 1);
    @(negedge clk);
    chk("e_cyc1_state", int'(curr_state), 1);
    chk("e_cyc1_count", int'(fifo_count), 0);
    @(negedge clk);
    chk("e_cyc2_light", int'(light_on), 1);
    n = 1;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("e_busy_cycles", n, 17);
    chk("e_end_state", int'(curr_state), 0);
    wait_idle(100);

    // A: state sequence
    sb.push_back(0);
    push(0);
    prev = 3'd0;
    seq  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (curr_state != prev) begin
        seq  = (seq << 3) | int'(curr_state);
        prev = curr_state;
        if (curr_state == 3'd0) break;
      end
    end
    chk("a_state_seq", seq, 18'o123240);
    wait_idle(100);

    // B,H,C,D,G back-to-back, then an overflowing push
    sb.push_back(1); push(1);
    sb.push_back(7); push(7);
    sb.push_back(2); push(2);
    sb.push_back(3); push(3);
    sb.push_back(6); push(6);
    chk("burst_count", int'(fifo_count), 4);
    chk("burst_full",  int'(fifo_full),  1);
    push(0);
    chk("ovf_pulse", int'(overflow),   1);
    chk("ovf_count", int'(fifo_count), 4);
    @(negedge clk);
    chk("ovf_pulse_end", int'(overflow), 0);

    // Push on the LGAP->LOAD pop edge while full
    n = 0;
    while (!(ltr_done && fifo_full) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("gap_full_reached", int'(ltr_done && fifo_full), 1);
    sb.push_back(4);
    push(4);
    chk("pp_count",    int'(fifo_count), 4);
    chk("pp_overflow", int'(overflow),   0);
    chk("pp_state",    int'(curr_state), 1);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("burst_busy_run", n, 205);
    wait_idle(100);

    // Reset mid-dash of G with D queued behind it
    push(6);
    push(3);
    repeat (4) @(negedge clk);
    chk("g_mid_dash_light", int'(light_on),   1);
    chk("g_mid_dash_count", int'(fifo_count), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_light_on",   int'(light_on),   0);
    chk("abort_busy",       int'(busy),       0);
    chk("abort_fifo_count", int'(fifo_count), 0);
    chk("abort_state",      int'(curr_state), 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", int'(curr_state), 0);
    chk("post_rst_busy",  int'(busy),       0);
    sb.push_back(5);
    push(5);
    wait_idle(200);

    // Sweep all letters
    for (int c = 0; c < 8; c++) begin
      sb.push_back(c);
      push(c);
      wait_idle(200);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("overflow_pulses",    ovf_seen,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/morse_tx_sequencer.md
Name: morse_tx_sequencer

Overview:
- Controller that queues Morse letters A–H and plays them one after another on a single light output.
- Each letter is looked up in an internal table, loaded into a symbol shift register and counter, and timed in half-second ticks from an internal prescaler.
- Dots, dashes, intra-letter gaps and inter-letter gaps are sequenced automatically.
- Sits between the board switches/KEY debounce logic and the LEDR driver; replaces hand-sequencing of the letter FSM.

Parameters:
- TICK_CYCLES, 25000000, clk cycles per time unit (0.5 s at 50 MHz); minimum 2.
- LETTER_GAP, 3, dark time units after each letter; range 1..7.
- FIFO_DEPTH, 4, letter queue entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- ld_ltr  in  1  single-cycle push strobe; already debounced and edge-detected upstream.
- in_ltr  in  3  letter code: 0=A, 1=B, … 7=H; sampled when ld_ltr=1.
- light_on  out  1  Morse light, registered.
- busy  out  1  high whenever curr_state != IDLE.
- ltr_done  out  1  one-cycle pulse at the end of each letter's gap.
- fifo_full  out  1  queue holds FIFO_DEPTH entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued letters.
- overflow  out  1  one-cycle pulse when a push is dropped because the queue is full.
- curr_state  out  3  encoded state, for debug on LEDs.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs go to 0.
  - FIFO empties; state goes to IDLE.
  - Tick, duration and symbol counters clear.
  - Reset mid-letter aborts the letter immediately; light_on=0 in the same instant.
- Code table (len, pattern; bit0 is the first symbol, 1=dash):
  - A=2,'b10; B=4,'b0001; C=4,'b0101; D=3,'b001.
  - E=1,'b0; F=4,'b0100; G=3,'b011; H=4,'b0000.
- FIFO:
  - Push on a rising edge with ld_ltr=1 and not full; pop on entry to LOAD.
  - Simultaneous push and pop: both occur, count unchanged. A push while full is allowed only if a pop happens in the same cycle; otherwise it is dropped and overflow pulses.
  - Pointers wrap modulo FIFO_DEPTH.
- Tick counter:
  - Cleared in IDLE and LOAD, and whenever a duration expires.
  - Otherwise counts 0..TICK_CYCLES-1; tick is asserted at TICK_CYCLES-1.
- States (encoding): IDLE=0, LOAD=1, MARK=2, SPACE=3, LGAP=4. Encodings 5–7 are illegal and recover to IDLE.
  - IDLE: if fifo_count>0, go to LOAD next cycle.
  - LOAD (exactly 1 cycle): pop the letter; load shift register and symbol count from the table; duration = pattern bit0 ? 3 : 1; go to MARK.
  - MARK:
    - light_on=1.
    - Lasts exactly duration*TICK_CYCLES cycles.
    - Then, if symbols remain > 1: go to SPACE with duration 1.
    - Otherwise: go to LGAP with duration LETTER_GAP.
  - SPACE:
    - light_on=0.
    - Lasts TICK_CYCLES cycles.
    - Then shift the pattern right, decrement the symbol count, set duration from the new bit0, and go to MARK.
  - LGAP:
    - light_on=0.
    - Lasts LETTER_GAP*TICK_CYCLES cycles.
    - At the end, pulse ltr_done, then go to LOAD if fifo_count>0, else IDLE.
- Timing:
  - light_on is driven directly from a state register: high for exactly the cycles spent in MARK.
  - Push to first light_on latency from IDLE is 2 cycles (edge k push, k+1 LOAD, k+2 MARK).
  - Back-to-back letters: LGAP exits directly to LOAD, so there is no IDLE cycle between letters.
- ld_ltr is accepted in every state, including during playback.

Test Plan:
- TICK_CYCLES=4, LETTER_GAP=3; push E at cycle 0 → LOAD at 1; light_on high cycles 2–5; low for 12 cycles; ltr_done pulse on the last LGAP cycle; IDLE after; busy high for 17 cycles.
- Push A → light pattern 4 on / 4 off / 12 on / 12 off; curr_state sequence 1,2,3,2,4,0.
- Push B,H,C,D,G back-to-back with FIFO_DEPTH=4:
  - fifo_full asserts after the 4th entry is queued; B is popped at once, so C,D,G fill the queue behind H.
  - Any 5th push while full → overflow pulse; that push is dropped and fifo_count stays 4.
  - The letters play in order with no IDLE between them.
- Push issued on the same edge as a pop from LGAP→LOAD while full → accepted, fifo_count unchanged, no overflow.
- Assert reset_n=0 mid-dash of G → light_on, busy and fifo_count are 0 immediately. After release, state is IDLE; a new push of F plays correctly (..-.).
- Sweep all 8 letters → measured mark widths match the code table (1 unit = 4 cycles, 3 units = 12 cycles); total letter time = (sum of marks + (len-1) + LETTER_GAP)*4 cycles.
